// File: rtl/pwm_lbus.sv
// Multi-channel PWM generator on the XT_LB low-speed bus. It has a shared prescaler and period counter,
// double-buffered period and duty registers, per-channel polarity, and a period-wrap interrupt.
module pwm_lbus #(
    parameter int         NUM_CH    = 4,
    parameter int         CNT_WIDTH = 16,
    parameter logic [7:0] BASE_ADDR = 8'd40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        lb_addr,
    input  logic              lb_wen,
    input  logic              lb_ren,
    input  logic [31:0]       lb_wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    localparam int         NUM_REGS = NUM_CH + 5;
    localparam logic [7:0] OFF_CTRL = 8'd0;
    localparam logic [7:0] OFF_PSC  = 8'd1;
    localparam logic [7:0] OFF_PER  = 8'd2;
    localparam logic [7:0] OFF_STAT = 8'(3 + NUM_CH);
    localparam logic [7:0] OFF_CNT  = 8'(4 + NUM_CH);

    logic [7:0]           off;
    logic                 hit;
    logic                 wr;
    logic                 wr_ctrl;
    logic                 update;
    logic                 en_rise;
    logic                 tick;
    logic                 wrap;
    logic                 reload;
    logic [31:0]          rd_word;
    logic                 unused;

    logic                 en;
    logic                 irq_en;
    logic [NUM_CH-1:0]    ch_en;
    logic [NUM_CH-1:0]    pol;
    logic [CNT_WIDTH-1:0] prescale;
    logic [CNT_WIDTH-1:0] period;
    logic [CNT_WIDTH-1:0] duty    [NUM_CH];
    logic [CNT_WIDTH-1:0] period_sh;
    logic [CNT_WIDTH-1:0] duty_sh [NUM_CH];
    logic [CNT_WIDTH-1:0] psc_cnt;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 wrap_flag;

    assign off     = lb_addr - BASE_ADDR;
    assign hit     = (lb_addr >= BASE_ADDR) && (off < 8'(NUM_REGS));
    assign wr      = lb_wen && hit;
    assign wr_ctrl = wr && (off == OFF_CTRL);
    assign update  = wr_ctrl && lb_wdata[31];
    assign en_rise = wr_ctrl && lb_wdata[0] && !en;
    // The >= recovers at once if PRESCALE is lowered below the running count.
    assign tick    = en && (psc_cnt >= prescale);
    // UPDATE restarts the period, so a coincident wrap is dropped (no flag, no irq).
    assign wrap    = tick && (cnt == period_sh) && !update;
    assign reload  = wrap || en_rise || update;
    assign unused  = ^lb_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en       <= 1'b0;
            irq_en   <= 1'b0;
            ch_en    <= '0;
            pol      <= '0;
            prescale <= '0;
            period   <= '0;
            // NOTE: duty is a small flop array, not a RAM, so it is reset like any other register.
            for (int i = 0; i < NUM_CH; i++) duty[i] <= '0;
        end else begin
            if (wr_ctrl) begin
                en     <= lb_wdata[0];
                irq_en <= lb_wdata[1];
                ch_en  <= lb_wdata[8 +: NUM_CH];
                pol    <= lb_wdata[16 +: NUM_CH];
            end
            if (wr && off == OFF_PSC) prescale <= lb_wdata[CNT_WIDTH-1:0];
            if (wr && off == OFF_PER) period   <= lb_wdata[CNT_WIDTH-1:0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr && off == 8'(3 + i)) duty[i] <= lb_wdata[CNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_cnt <= '0;
            cnt     <= '0;
        end else if (!en || update) begin
            psc_cnt <= '0;
            cnt     <= '0;
        end else if (tick) begin
            psc_cnt <= '0;
            cnt     <= (cnt == period_sh) ? '0 : cnt + 1'b1;
        end else begin
            psc_cnt <= psc_cnt + 1'b1;
        end
    end

    // Shadows sample the active registers as they were before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_sh <= '0;
            for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= '0;
        end else if (reload) begin
            period_sh <= period;
            for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= duty[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_flag <= 1'b0;
            irq       <= 1'b0;
            pwm_out   <= '0;
        end else begin
            if (wrap)
                wrap_flag <= 1'b1;
            else if (wr && off == OFF_STAT && lb_wdata[0])
                wrap_flag <= 1'b0;
            irq <= wrap && irq_en;
            for (int i = 0; i < NUM_CH; i++)
                pwm_out[i] <= (en && ch_en[i] && (cnt < duty_sh[i])) ^ pol[i];
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns rd_word and no latch is inferred.
        rd_word = '0;
        if (off == OFF_CTRL) begin
            rd_word[0]              = en;
            rd_word[1]              = irq_en;
            rd_word[8 +: NUM_CH]    = ch_en;
            rd_word[16 +: NUM_CH]   = pol;
        end else if (off == OFF_PSC) begin
            rd_word[CNT_WIDTH-1:0]  = prescale;
        end else if (off == OFF_PER) begin
            rd_word[CNT_WIDTH-1:0]  = period;
        end else if (off == OFF_STAT) begin
            rd_word[0]              = wrap_flag;
        end else if (off == OFF_CNT) begin
            rd_word[CNT_WIDTH-1:0]  = cnt;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (off == 8'(3 + i)) rd_word[CNT_WIDTH-1:0] = duty[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else
            rdata <= (lb_ren && hit) ? rd_word : '0;
    end

endmodule

// File: tb/tb_pwm_lbus.sv
// Directed bench for pwm_lbus. Expected read data is queued when a read is issued and a monitor checks it one
// cycle later. The bench checks waveform, irq and reset values against hand-derived cycle patterns.
module tb_pwm_lbus;

    localparam int         NUM_CH  = 4;
    localparam logic [7:0] A_CTRL  = 8'd40;
    localparam logic [7:0] A_PSC   = 8'd41;
    localparam logic [7:0] A_PER   = 8'd42;
    localparam logic [7:0] A_DUTY0 = 8'd43;
    localparam logic [7:0] A_DUTY1 = 8'd44;
    localparam logic [7:0] A_DUTY2 = 8'd45;
    localparam logic [7:0] A_DUTY3 = 8'd46;
    localparam logic [7:0] A_STAT  = 8'd47;
    localparam logic [7:0] A_CNT   = 8'd48;
    localparam logic [7:0] A_NONE  = 8'd49;

    logic              clk;
    logic              rst;
    logic [7:0]        lb_addr;
    logic              lb_wen;
    logic              lb_ren;
    logic [31:0]       lb_wdata;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] pwm_out;
    logic              irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];

    pwm_lbus #(.NUM_CH(NUM_CH), .CNT_WIDTH(16), .BASE_ADDR(8'd40)) dut (
        .clk      (clk),
        .rst      (rst),
        .lb_addr  (lb_addr),
        .lb_wen   (lb_wen),
        .lb_ren   (lb_ren),
        .lb_wdata (lb_wdata),
        .rdata    (rdata),
        .pwm_out  (pwm_out),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
        end
    endtask

    // All bus tasks start on a negedge and return on the next one: exactly one cycle each.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        lb_addr  = a;
        lb_wdata = d;
        lb_wen   = 1'b1;
        @(negedge clk);
        lb_wen   = 1'b0;
        lb_wdata = '0;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [31:0] want, input string name);
        exp_q.push_back(want);
        name_q.push_back(name);
        lb_addr = a;
        lb_ren  = 1'b1;
        @(negedge clk);
        lb_ren  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Read-data monitor: rdata is checked 1 ns after the edge that captured a read strobe.
    initial begin
        logic        ren_s;
        logic [31:0] want;
        forever begin
            @(posedge clk);
            ren_s = lb_ren;
            #1;
            if (ren_s) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL read_underflow: got 0x%08h with no expected value queued", rdata);
                end else begin
                    want = exp_q.pop_front();
                    check(name_q.pop_front(), rdata, want);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ph;
        int d;
        rst      = 1'b1;
        lb_addr  = '0;
        lb_wen   = 1'b0;
        lb_ren   = 1'b0;
        lb_wdata = '0;
        idle(3);
        check("reset_pwm", 32'(pwm_out), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_rdata", rdata, 32'h0);
        rst = 1'b0;

        // Register write and readback
        bus_write(A_PER, 32'd9);
        bus_write(A_DUTY0, 32'd3);
        bus_write(A_PSC, 32'd0);
        bus_read(A_PER, 32'd9, "rd_period");
        @(negedge clk);
        check("rdata_idle_zero", rdata, 32'h0);
        bus_read(A_DUTY0, 32'd3, "rd_duty0");
        bus_read(A_PSC, 32'd0, "rd_prescale");
        bus_read(A_CNT, 32'd0, "rd_count_idle");
        bus_read(A_CTRL, 32'd0, "rd_ctrl_idle");
        bus_read(A_STAT, 32'd0, "rd_status_idle");
        bus_write(A_NONE, 32'hFFFF_FFFF);
        bus_read(A_NONE, 32'd0, "rd_unmapped");
        check("pwm_idle", 32'(pwm_out), 32'h0);

        // Basic PWM: 3 high, 7 low, 10-cycle period
        bus_write(A_CTRL, 32'h0000_0101);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("basic_pwm k=%0d", k), 32'(pwm_out[0]), 32'(((k - 1) % 10) < 3));
        end
        bus_read(A_STAT, 32'd1, "rd_wrap_flag_set");

        // Prescaler 1, period 4 gives 10 cycles; irq pulses on each wrap
        bus_write(A_PSC, 32'd1);
        bus_write(A_PER, 32'd4);
        bus_write(A_CTRL, 32'h8000_0103);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check($sformatf("psc_pwm k=%0d", k), 32'(pwm_out[0]), 32'(((k - 1) % 10) < 6));
            check($sformatf("psc_irq k=%0d", k), 32'(irq), 32'((k % 10) == 0));
        end
        bus_read(A_STAT, 32'd1, "rd_flag_before_clear");
        bus_write(A_STAT, 32'd1);
        bus_read(A_STAT, 32'd0, "rd_flag_cleared");
        idle(6);
        bus_write(A_STAT, 32'd1);
        bus_read(A_STAT, 32'd1, "rd_flag_set_beats_clear");
        bus_read(A_CTRL, 32'h0000_0103, "rd_ctrl_update_reads0");

        // Double buffering: mid-period write and write on the wrap cycle
        bus_write(A_PSC, 32'd0);
        bus_write(A_PER, 32'd9);
        bus_write(A_CTRL, 32'h8000_0103);
        for (int k = 1; k <= 40; k++) begin
            if (k == 5)
                bus_write(A_DUTY0, 32'd8);
            else if (k == 20)
                bus_write(A_DUTY0, 32'd5);
            else
                @(negedge clk);
            ph = (k - 1) / 10;
            d  = (ph == 0) ? 3 : (ph <= 2) ? 8 : 5;
            check($sformatf("dbuf_pwm k=%0d", k), 32'(pwm_out[0]), 32'(((k - 1) % 10) < d));
        end

        // Boundaries: duty 0, duty > period, inverted polarity
        bus_write(A_DUTY1, 32'd0);
        bus_write(A_DUTY2, 32'd12);
        bus_write(A_DUTY3, 32'd3);
        bus_write(A_CTRL, 32'h8008_0F03);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ph = (k - 1) % 10;
            check($sformatf("bound_pwm k=%0d", k), 32'(pwm_out),
                  32'({!(ph < 3), 1'b1, 1'b0, (ph < 5)}));
        end
        bus_read(A_CTRL, 32'h0008_0F03, "rd_ctrl_all_ch");
        bus_write(A_CTRL, 32'h0008_0F00);
        @(negedge clk);
        check("disabled_pol_1000", 32'(pwm_out), 32'h8);
        bus_read(A_CNT, 32'd0, "rd_count_disabled");
        bus_write(A_CTRL, 32'h0005_0F00);
        @(negedge clk);
        check("disabled_pol_0101", 32'(pwm_out), 32'h5);

        // UPDATE restarts the count and wins over a coincident wrap
        bus_write(A_STAT, 32'd1);
        bus_write(A_CTRL, 32'h000E_0103);
        idle(4);
        bus_read(A_CNT, 32'd4, "rd_count_running");
        bus_write(A_CTRL, 32'h800E_0103);
        check("update_no_irq", 32'(irq), 32'h0);
        bus_read(A_CNT, 32'd0, "rd_count_after_update");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("no_irq k=%0d", k), 32'(irq), 32'h0);
        end
        bus_write(A_CTRL, 32'h800E_0103);
        check("update_over_wrap_irq", 32'(irq), 32'h0);
        @(negedge clk);
        check("pwm_before_reset", 32'(pwm_out), 32'hF);

        // Asynchronous reset mid-period
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_pwm", 32'(pwm_out), 32'h0);
        check("async_reset_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus_read(A_CTRL, 32'd0, "rst_ctrl");
        bus_read(A_PSC, 32'd0, "rst_prescale");
        bus_read(A_PER, 32'd0, "rst_period");
        bus_read(A_DUTY0, 32'd0, "rst_duty0");
        bus_read(A_DUTY1, 32'd0, "rst_duty1");
        bus_read(A_DUTY2, 32'd0, "rst_duty2");
        bus_read(A_DUTY3, 32'd0, "rst_duty3");
        bus_read(A_STAT, 32'd0, "rst_status");
        bus_read(A_CNT, 32'd0, "rst_count");
        check("rst_pwm_after", 32'(pwm_out), 32'h0);

        idle(2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
